// File: rtl/i2c_txn_arbiter_pkg.sv
// Shared types for the I2C transaction arbiter: command word, FSM states, limits.
package i2c_txn_arbiter_pkg;

    localparam int unsigned I2C_ARB_MAX_REQ = 8;

    typedef struct packed {
        logic [6:0] addr;
        logic       we;
        logic [7:0] burst_num;
    } t_i2c_cmd;

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        DATA
    } t_i2c_arb_state;

endpackage

// File: rtl/i2c_txn_arbiter_rr_pick.sv
// Combinational round-robin finder: first asserted request at or after the pointer,
// wrapping modulo NUM_REQ.
module i2c_rr_pick #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic               o_found,
    output logic [IDX_W-1:0]   o_idx
);

    always_comb begin
        int unsigned cand;
        o_found = 1'b0;
        o_idx   = '0;
        cand    = 0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            // Pointer is always < NUM_REQ, so one subtraction completes the wrap.
            cand = 32'(i_ptr) + off;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!o_found && i_req[cand[IDX_W-1:0]]) begin
                o_found = 1'b1;
                o_idx   = cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/i2c_txn_arbiter.sv
// Round-robin arbiter granting whole I2C transactions (command plus data bytes) to one
// of NUM_REQ requesters. Define I2C_ARB_STATS_EN to add per-requester completion counters.
module i2c_txn_arbiter
    import i2c_txn_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_enable,
    input  logic [NUM_REQ-1:0] i_req_cmd_valid,
    input  t_i2c_cmd           i_req_cmd_data [NUM_REQ],
    output logic [NUM_REQ-1:0] o_req_cmd_ready,
    input  logic [NUM_REQ-1:0] i_req_wr_valid,
    input  logic [7:0]         i_req_wr_data [NUM_REQ],
    output logic [NUM_REQ-1:0] o_req_wr_ready,
    output logic [NUM_REQ-1:0] o_req_rd_valid,
    output logic [7:0]         o_req_rd_data,
    input  logic [NUM_REQ-1:0] i_req_rd_ready,
    output logic               o_cmd_valid,
    output t_i2c_cmd           o_cmd_data,
    input  logic               i_cmd_ready,
    output logic               o_wr_valid,
    output logic [7:0]         o_wr_data,
    input  logic               i_wr_ready,
    input  logic               i_rd_valid,
    input  logic [7:0]         i_rd_data,
    output logic               o_rd_ready,
`ifdef I2C_ARB_STATS_EN
    output logic [15:0]        o_txn_count [NUM_REQ],
`endif
    output logic               o_busy,
    output logic [IDX_W-1:0]   o_grant_idx
);

    t_i2c_arb_state   state_q, state_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic             busy_q, busy_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             we_q, we_d;
    logic [7:0]       burst_q, burst_d;

    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;
    logic             byte_hs;
    logic             txn_done;

    i2c_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .i_req   (i_req_cmd_valid),
        .i_ptr   (ptr_q),
        .o_found (pick_found),
        .o_idx   (pick_idx)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            burst_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            burst_q <= burst_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        grant_d         = grant_q;
        ptr_d           = ptr_q;
        busy_d          = busy_q;
        cnt_d           = cnt_q;
        we_d            = we_q;
        burst_d         = burst_q;
        byte_hs         = 1'b0;
        txn_done        = 1'b0;
        o_cmd_valid     = 1'b0;
        o_cmd_data      = '0;
        o_req_cmd_ready = '0;
        o_wr_valid      = 1'b0;
        o_wr_data       = '0;
        o_req_wr_ready  = '0;
        o_req_rd_valid  = '0;
        o_req_rd_data   = '0;
        o_rd_ready      = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_enable && pick_found) begin
                    grant_d = pick_idx;
                    busy_d  = 1'b1;
                    state_d = CMD;
                end
            end

            CMD: begin
                o_cmd_valid              = i_req_cmd_valid[grant_q];
                o_cmd_data               = i_req_cmd_data[grant_q];
                o_req_cmd_ready[grant_q] = i_cmd_ready;
                if (o_cmd_valid && i_cmd_ready) begin
                    we_d    = o_cmd_data.we;
                    burst_d = o_cmd_data.burst_num;
                    cnt_d   = '0;
                    state_d = DATA;
                end
            end

            DATA: begin
                if (we_q) begin
                    o_wr_valid              = i_req_wr_valid[grant_q];
                    o_wr_data               = i_req_wr_data[grant_q];
                    o_req_wr_ready[grant_q] = i_wr_ready;
                    byte_hs                 = o_wr_valid && i_wr_ready;
                end else begin
                    o_req_rd_valid[grant_q] = i_rd_valid;
                    o_rd_ready              = i_req_rd_ready[grant_q];
                    o_req_rd_data           = i_rd_data;
                    byte_hs                 = i_rd_valid && o_rd_ready;
                end
                if (byte_hs) begin
                    if (cnt_q == burst_q) begin
                        txn_done = 1'b1;
                        cnt_d    = '0;
                        busy_d   = 1'b0;
                        state_d  = IDLE;
                        ptr_d    = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    assign o_busy      = busy_q;
    assign o_grant_idx = grant_q;

`ifdef I2C_ARB_STATS_EN
    logic [15:0] txn_cnt_q [NUM_REQ];
    logic [15:0] txn_cnt_d [NUM_REQ];

    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            txn_cnt_d[i] = txn_cnt_q[i];
            if (txn_done && (grant_q == IDX_W'(i)) && (txn_cnt_q[i] != '1)) begin
                txn_cnt_d[i] = txn_cnt_q[i] + 16'd1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                txn_cnt_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                txn_cnt_q[i] <= txn_cnt_d[i];
            end
        end
    end

    assign o_txn_count = txn_cnt_q;
`endif

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Directed self-checking bench for i2c_txn_arbiter (two requesters); covers the
// stats counters when I2C_ARB_STATS_EN is defined.
module tb_i2c_txn_arbiter;
    import i2c_txn_arbiter_pkg::*;

    localparam int unsigned N = 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           enable;
    logic [N-1:0]   req_cmd_valid;
    t_i2c_cmd       req_cmd_data [N];
    logic [N-1:0]   req_cmd_ready;
    logic [N-1:0]   req_wr_valid;
    logic [7:0]     req_wr_data [N];
    logic [N-1:0]   req_wr_ready;
    logic [N-1:0]   req_rd_valid;
    logic [7:0]     req_rd_data;
    logic [N-1:0]   req_rd_ready;
    logic           cmd_valid;
    t_i2c_cmd       cmd_data;
    logic           cmd_ready;
    logic           wr_valid;
    logic [7:0]     wr_data;
    logic           wr_ready;
    logic           rd_valid;
    logic [7:0]     rd_data;
    logic           rd_ready;
    logic           busy;
    logic [0:0]     grant_idx;
`ifdef I2C_ARB_STATS_EN
    logic [15:0]    txn_count [N];
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    i2c_txn_arbiter #(
        .NUM_REQ (N)
    ) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_enable        (enable),
        .i_req_cmd_valid (req_cmd_valid),
        .i_req_cmd_data  (req_cmd_data),
        .o_req_cmd_ready (req_cmd_ready),
        .i_req_wr_valid  (req_wr_valid),
        .i_req_wr_data   (req_wr_data),
        .o_req_wr_ready  (req_wr_ready),
        .o_req_rd_valid  (req_rd_valid),
        .o_req_rd_data   (req_rd_data),
        .i_req_rd_ready  (req_rd_ready),
        .o_cmd_valid     (cmd_valid),
        .o_cmd_data      (cmd_data),
        .i_cmd_ready     (cmd_ready),
        .o_wr_valid      (wr_valid),
        .o_wr_data       (wr_data),
        .i_wr_ready      (wr_ready),
        .i_rd_valid      (rd_valid),
        .i_rd_data       (rd_data),
        .o_rd_ready      (rd_ready),
`ifdef I2C_ARB_STATS_EN
        .o_txn_count     (txn_count),
`endif
        .o_busy          (busy),
        .o_grant_idx     (grant_idx)
    );

    function automatic t_i2c_cmd mk_cmd(input logic [6:0] addr, input logic we,
                                        input logic [7:0] burst);
        t_i2c_cmd c;
        c.addr      = addr;
        c.we        = we;
        c.burst_num = burst;
        return c;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req_cmd_valid   = '0;
        req_cmd_data[0] = '0;
        req_cmd_data[1] = '0;
        req_wr_valid    = '0;
        req_wr_data[0]  = '0;
        req_wr_data[1]  = '0;
        req_rd_ready    = '0;
        cmd_ready       = 1'b0;
        wr_ready        = 1'b0;
        rd_valid        = 1'b0;
        rd_data         = '0;
    endtask

    task automatic test_reset();
        clear_inputs();
        enable        = 1'b1;
        rst_n         = 1'b0;
        req_cmd_valid = 2'b11;
        rd_valid      = 1'b1;
        rd_data       = 8'hFF;
        cmd_ready     = 1'b1;
        wr_ready      = 1'b1;
        #2;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_checks++; if (grant_idx !== 1'b0) begin n_fail++; $display("FAIL rst_grant: got %b want 0", grant_idx); end
        n_checks++; if (cmd_valid !== 1'b0 || cmd_data !== '0) begin n_fail++; $display("FAIL rst_cmd: got v=%b d=%h want 0/0", cmd_valid, cmd_data); end
        n_checks++; if (req_cmd_ready !== 2'b00 || req_wr_ready !== 2'b00) begin n_fail++; $display("FAIL rst_readys: got %b %b want 00 00", req_cmd_ready, req_wr_ready); end
        n_checks++; if (req_rd_valid !== 2'b00 || req_rd_data !== 8'h00) begin n_fail++; $display("FAIL rst_rd: got %b %h want 00 00", req_rd_valid, req_rd_data); end
        n_checks++; if (wr_valid !== 1'b0 || wr_data !== 8'h00 || rd_ready !== 1'b0) begin n_fail++; $display("FAIL rst_master: got %b %h %b want 0 00 0", wr_valid, wr_data, rd_ready); end
`ifdef I2C_ARB_STATS_EN
        n_checks++; if (txn_count[0] !== 16'd0 || txn_count[1] !== 16'd0) begin n_fail++; $display("FAIL rst_stats: got %0d %0d want 0 0", txn_count[0], txn_count[1]); end
`endif
        clear_inputs();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_write();
        t_i2c_cmd c;
        c               = mk_cmd(7'h21, 1'b1, 8'd3);
        req_cmd_data[0] = c;
        req_cmd_valid   = 2'b01;
        req_wr_valid    = 2'b01;
        req_wr_data[0]  = 8'hA0;
        cmd_ready       = 1'b1;
        wr_ready        = 1'b1;
        #1;
        n_checks++; if (cmd_valid !== 1'b0 || req_cmd_ready !== 2'b00) begin n_fail++; $display("FAIL wr_idle_cmd: got v=%b rdy=%b want 0 00", cmd_valid, req_cmd_ready); end
        step();
        n_checks++; if (busy !== 1'b1 || grant_idx !== 1'b0) begin n_fail++; $display("FAIL wr_grant: got busy=%b g=%b want 1 0", busy, grant_idx); end
        n_checks++; if (cmd_valid !== 1'b1 || cmd_data !== c) begin n_fail++; $display("FAIL wr_cmd: got v=%b d=%h want 1 %h", cmd_valid, cmd_data, c); end
        n_checks++; if (req_cmd_ready !== 2'b01 || wr_valid !== 1'b0) begin n_fail++; $display("FAIL wr_cmd_rdy: got rdy=%b wv=%b want 01 0", req_cmd_ready, wr_valid); end
        step();
        req_cmd_valid = 2'b00;
        for (int k = 0; k < 4; k++) begin
            req_wr_data[0] = 8'hA0 + 8'(k);
            #1;
            n_checks++; if (wr_valid !== 1'b1 || wr_data !== 8'hA0 + 8'(k)) begin n_fail++; $display("FAIL wr_byte[%0d]: got v=%b d=%h want 1 %h", k, wr_valid, wr_data, 8'hA0 + 8'(k)); end
            n_checks++; if (req_wr_ready !== 2'b01 || busy !== 1'b1) begin n_fail++; $display("FAIL wr_byte_rdy[%0d]: got rdy=%b busy=%b want 01 1", k, req_wr_ready, busy); end
            step();
        end
        n_checks++; if (busy !== 1'b0 || wr_valid !== 1'b0 || grant_idx !== 1'b0) begin n_fail++; $display("FAIL wr_done: got busy=%b wv=%b g=%b want 0 0 0", busy, wr_valid, grant_idx); end
        req_wr_valid = 2'b00;
    endtask

    task automatic test_read();
        t_i2c_cmd c1;
        c1              = mk_cmd(7'h48, 1'b0, 8'd1);
        req_cmd_data[0] = mk_cmd(7'h22, 1'b1, 8'd0);
        req_cmd_data[1] = c1;
        req_cmd_valid   = 2'b11;
        req_rd_ready    = 2'b11;
        cmd_ready       = 1'b1;
        step();
        n_checks++; if (grant_idx !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL rd_grant_ptr: got g=%b busy=%b want 1 1", grant_idx, busy); end
        n_checks++; if (req_cmd_ready !== 2'b10 || cmd_data !== c1) begin n_fail++; $display("FAIL rd_cmd: got rdy=%b d=%h want 10 %h", req_cmd_ready, cmd_data, c1); end
        req_cmd_valid = 2'b10;
        step();
        req_cmd_valid = 2'b00;
        rd_valid      = 1'b1;
        rd_data       = 8'h5A;
        #1;
        n_checks++; if (req_rd_valid !== 2'b10 || req_rd_data !== 8'h5A) begin n_fail++; $display("FAIL rd_byte0: got v=%b d=%h want 10 5a", req_rd_valid, req_rd_data); end
        n_checks++; if (rd_ready !== 1'b1 || wr_valid !== 1'b0 || req_wr_ready !== 2'b00) begin n_fail++; $display("FAIL rd_byte0_dir: got rr=%b wv=%b wr=%b want 1 0 00", rd_ready, wr_valid, req_wr_ready); end
        step();
        rd_valid = 1'b0;
        #1;
        n_checks++; if (req_rd_valid !== 2'b00 || busy !== 1'b1) begin n_fail++; $display("FAIL rd_gap: got v=%b busy=%b want 00 1", req_rd_valid, busy); end
        step();
        rd_valid = 1'b1;
        rd_data  = 8'hC3;
        #1;
        n_checks++; if (req_rd_valid !== 2'b10 || req_rd_data !== 8'hC3) begin n_fail++; $display("FAIL rd_byte1: got v=%b d=%h want 10 c3", req_rd_valid, req_rd_data); end
        step();
        n_checks++; if (busy !== 1'b0 || req_rd_valid !== 2'b00 || rd_ready !== 1'b0) begin n_fail++; $display("FAIL rd_done: got busy=%b v=%b rr=%b want 0 00 0", busy, req_rd_valid, rd_ready); end
        rd_valid     = 1'b0;
        req_rd_ready = 2'b00;
    endtask

    task automatic test_fairness();
        req_cmd_data[0] = mk_cmd(7'h30, 1'b1, 8'd0);
        req_cmd_data[1] = mk_cmd(7'h31, 1'b1, 8'd0);
        req_wr_data[0]  = 8'h10;
        req_wr_data[1]  = 8'h11;
        req_cmd_valid   = 2'b11;
        req_wr_valid    = 2'b11;
        cmd_ready       = 1'b1;
        wr_ready        = 1'b1;
        for (int t = 0; t < 6; t++) begin
            logic [0:0] exp_g;
            logic [1:0] exp_oh;
            exp_g  = 1'(t % 2);
            exp_oh = (t % 2 == 0) ? 2'b01 : 2'b10;
            step();
            n_checks++; if (grant_idx !== exp_g || busy !== 1'b1) begin n_fail++; $display("FAIL fair_grant[%0d]: got g=%b busy=%b want %b 1", t, grant_idx, busy, exp_g); end
            step();
            n_checks++; if (wr_data !== 8'h10 + 8'(exp_g) || req_wr_ready !== exp_oh) begin n_fail++; $display("FAIL fair_data[%0d]: got d=%h rdy=%b want %h %b", t, wr_data, req_wr_ready, 8'h10 + 8'(exp_g), exp_oh); end
            step();
            n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL fair_idle[%0d]: got busy=%b want 0", t, busy); end
        end
        req_cmd_valid = 2'b00;
        req_wr_valid  = 2'b00;
    endtask

    task automatic test_isolation_enable();
        req_cmd_data[0] = mk_cmd(7'h40, 1'b1, 8'd1);
        req_cmd_valid   = 2'b01;
        req_wr_valid    = 2'b11;
        req_wr_data[0]  = 8'h31;
        req_wr_data[1]  = 8'hEE;
        cmd_ready       = 1'b1;
        wr_ready        = 1'b1;
        step();
        step();
        req_cmd_valid = 2'b00;
        #1;
        n_checks++; if (req_wr_ready !== 2'b01 || wr_data !== 8'h31) begin n_fail++; $display("FAIL iso_byte0: got rdy=%b d=%h want 01 31", req_wr_ready, wr_data); end
        wr_ready = 1'b0;
        enable   = 1'b0;
        #1;
        n_checks++; if (req_wr_ready !== 2'b00 || wr_valid !== 1'b1) begin n_fail++; $display("FAIL iso_stall: got rdy=%b wv=%b want 00 1", req_wr_ready, wr_valid); end
        step();
        wr_ready = 1'b1;
        step();
        req_wr_data[0] = 8'h32;
        #1;
        n_checks++; if (busy !== 1'b1 || wr_data !== 8'h32 || req_wr_ready !== 2'b01) begin n_fail++; $display("FAIL iso_byte1: got busy=%b d=%h rdy=%b want 1 32 01", busy, wr_data, req_wr_ready); end
        step();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL dis_burst_done: got busy=%b want 0", busy); end
        req_wr_valid    = 2'b10;
        req_cmd_data[1] = mk_cmd(7'h50, 1'b1, 8'd5);
        req_cmd_valid   = 2'b10;
        repeat (3) step();
        n_checks++; if (busy !== 1'b0 || cmd_valid !== 1'b0) begin n_fail++; $display("FAIL dis_no_grant: got busy=%b cv=%b want 0 0", busy, cmd_valid); end
        enable = 1'b1;
        step();
        n_checks++; if (busy !== 1'b1 || grant_idx !== 1'b1) begin n_fail++; $display("FAIL en_grant: got busy=%b g=%b want 1 1", busy, grant_idx); end
    endtask

    task automatic test_reset_mid_burst();
        req_wr_data[1] = 8'h61;
        step();
        req_cmd_valid = 2'b00;
        step();
        step();
        n_checks++; if (busy !== 1'b1 || wr_valid !== 1'b1 || wr_data !== 8'h61) begin n_fail++; $display("FAIL rmb_pre: got busy=%b wv=%b d=%h want 1 1 61", busy, wr_valid, wr_data); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0 || grant_idx !== 1'b0) begin n_fail++; $display("FAIL rmb_state: got busy=%b g=%b want 0 0", busy, grant_idx); end
        n_checks++; if (wr_valid !== 1'b0 || req_wr_ready !== 2'b00 || wr_data !== 8'h00) begin n_fail++; $display("FAIL rmb_outs: got wv=%b rdy=%b d=%h want 0 00 00", wr_valid, req_wr_ready, wr_data); end
        clear_inputs();
        rst_n = 1'b1;
        step();
        req_cmd_data[0] = mk_cmd(7'h11, 1'b1, 8'd0);
        req_cmd_data[1] = mk_cmd(7'h12, 1'b1, 8'd0);
        req_cmd_valid   = 2'b11;
        req_wr_valid    = 2'b01;
        cmd_ready       = 1'b1;
        wr_ready        = 1'b1;
        step();
        n_checks++; if (grant_idx !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL rmb_ptr0: got g=%b busy=%b want 0 1", grant_idx, busy); end
        step();
        req_cmd_valid = 2'b00;
        step();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmb_after: got busy=%b want 0", busy); end
        clear_inputs();
    endtask

`ifdef I2C_ARB_STATS_EN
    task automatic test_stats();
        int seq [5];
        seq   = '{0, 1, 0, 1, 0};
        rst_n = 1'b0;
        #2;
        clear_inputs();
        rst_n = 1'b1;
        step();
        cmd_ready       = 1'b1;
        wr_ready        = 1'b1;
        req_cmd_data[0] = mk_cmd(7'h01, 1'b1, 8'd0);
        req_cmd_data[1] = mk_cmd(7'h02, 1'b1, 8'd0);
        for (int t = 0; t < 5; t++) begin
            req_cmd_valid = (seq[t] == 0) ? 2'b01 : 2'b10;
            req_wr_valid  = req_cmd_valid;
            step();
            step();
            req_cmd_valid = 2'b00;
            step();
            req_wr_valid = 2'b00;
        end
        n_checks++; if (txn_count[0] !== 16'd3 || txn_count[1] !== 16'd2) begin n_fail++; $display("FAIL stats_count: got %0d %0d want 3 2", txn_count[0], txn_count[1]); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n  = 1'b0;
        enable = 1'b0;
        clear_inputs();
        test_reset();
        test_write();
        test_read();
        test_fairness();
        test_isolation_enable();
        test_reset_mid_burst();
`ifdef I2C_ARB_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
